// File: rtl/timer_cnt_base.sv
// Timer time base: prescaler, auto-reload up-counter and run/stop control.
// Feeds the current count, run status and overflow pulse to the capture/compare channels.
module timer_cnt_base #(
    parameter int unsigned timer_width = 16,
    parameter int unsigned psc_width   = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   timer_en,
    input  logic                   timer_one_shot,
    input  logic [psc_width-1:0]   timer_psc,
    input  logic [timer_width-1:0] timer_arr,
    input  logic                   timer_cnt_set,
    input  logic [timer_width-1:0] timer_cnt_set_v,
    output logic [timer_width-1:0] timer_cnt_now_v,
    output logic                   timer_started,
    output logic                   timer_expired,
    output logic                   timer_exp_itr_req
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [psc_width-1:0]   psc_cnt_q, psc_cnt_d;
    logic [psc_width-1:0]   psc_sh_q, psc_sh_d;
    logic [timer_width-1:0] cnt_q, cnt_d;
    logic [timer_width-1:0] arr_sh_q, arr_sh_d;
    logic                   expired_q, expired_d;
    logic                   tick;
    logic                   ovf;

    // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        psc_cnt_d = psc_cnt_q;
        psc_sh_d  = psc_sh_q;
        cnt_d     = cnt_q;
        arr_sh_d  = arr_sh_q;
        expired_d = 1'b0;
        tick      = 1'b0;
        ovf       = 1'b0;

        if (timer_cnt_set) begin
            // Software load wins over everything, including a coincident overflow.
            cnt_d     = timer_cnt_set_v;
            psc_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (timer_en) begin
                        state_d   = RUN;
                        psc_sh_d  = timer_psc;
                        arr_sh_d  = timer_arr;
                        psc_cnt_d = '0;
                    end
                end
                RUN: begin
                    tick = (psc_cnt_q == psc_sh_q);
                    if (tick) begin
                        psc_cnt_d = '0;
                        // ">=" so a count left above a smaller new reload value still wraps.
                        if (cnt_q >= arr_sh_q) begin
                            ovf       = 1'b1;
                            cnt_d     = '0;
                            psc_sh_d  = timer_psc;
                            arr_sh_d  = timer_arr;
                            expired_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + timer_width'(1);
                        end
                    end else begin
                        psc_cnt_d = psc_cnt_q + psc_width'(1);
                    end
                    if (!timer_en || (ovf && timer_one_shot)) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            psc_cnt_q <= '0;
            psc_sh_q  <= '0;
            cnt_q     <= '0;
            arr_sh_q  <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            psc_cnt_q <= psc_cnt_d;
            psc_sh_q  <= psc_sh_d;
            cnt_q     <= cnt_d;
            arr_sh_q  <= arr_sh_d;
            expired_q <= expired_d;
        end
    end

    assign timer_cnt_now_v   = cnt_q;
    assign timer_started     = (state_q == RUN);
    assign timer_expired     = expired_q;
    assign timer_exp_itr_req = expired_q;

endmodule
